// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronises rx, counts 16x oversampling ticks,
// samples each bit at mid-bit, shifts LSB first and pulses rx_done_tick
// for one clk with the received word and the stop-bit framing error.
//
// Optional feature macro: UART_RX_PARITY_EN adds a PARITY state, the
// PAR_ODD parameter (0 = even) and the parity_err output.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   tick         one-clk oversampling strobe, OVS per bit period
//   rx           serial input, idle high, asynchronous to clk
//   dout         last received word, LSB = first bit on the wire
//   rx_done_tick one-clk pulse at frame completion (good or bad)
//   frame_err    1 if the stop bit sampled 0, held until next completion
//   parity_err   (UART_RX_PARITY_EN only) parity mismatch, held likewise
module uart_rx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned OVS     = 16
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit          PAR_ODD = 1'b0
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic            parity_err
`endif
);

   localparam int unsigned S_W = 5;
   localparam int unsigned N_W = $clog2(DBIT);

   localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
   localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
   localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
      ,
      PARITY = 3'd4
`endif
   } state_t;

   state_t          state, state_n;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic [S_W-1:0]  s_q, s_n;
   logic [N_W-1:0]  n_q, n_n;
   logic [DBIT-1:0] sh_q, sh_n;
   logic [DBIT-1:0] dout_n;
   logic            done_n;
   logic            ferr_n;
`ifdef UART_RX_PARITY_EN
   logic            pbad_q, pbad_n;
   logic            perr_n;
`endif

   assign rx_s = sync_q[1];

   // Metastability synchroniser; resets to the idle line level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], rx};
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         s_q          <= '0;
         n_q          <= '0;
         sh_q         <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pbad_q       <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         s_q          <= s_n;
         n_q          <= n_n;
         sh_q         <= sh_n;
         dout         <= dout_n;
         rx_done_tick <= done_n;
         frame_err    <= ferr_n;
`ifdef UART_RX_PARITY_EN
         pbad_q       <= pbad_n;
         parity_err   <= perr_n;
`endif
      end
   end

   // Next-state and datapath update; counters move only on tick
   always_comb begin
      state_n = state;
      s_n     = s_q;
      n_n     = n_q;
      sh_n    = sh_q;
      dout_n  = dout;
      done_n  = 1'b0;
      ferr_n  = frame_err;
`ifdef UART_RX_PARITY_EN
      pbad_n  = pbad_q;
      perr_n  = parity_err;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_q == S_MID) begin
                  // Line back high at mid start bit: treat as a glitch
                  if (!rx_s) begin
                     state_n = DATA;
                     s_n     = '0;
                     n_n     = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s_q + S_W'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_q == S_BIT) begin
                  s_n  = '0;
                  sh_n = {rx_s, sh_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end else begin
                     n_n = n_q + N_W'(1);
                  end
               end else begin
                  s_n = s_q + S_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (s_q == S_BIT) begin
                  s_n     = '0;
                  pbad_n  = (^sh_q) ^ rx_s ^ PAR_ODD;
                  state_n = STOP;
               end else begin
                  s_n = s_q + S_W'(1);
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (s_q == S_STOP) begin
                  dout_n  = sh_q;
                  ferr_n  = ~rx_s;
                  done_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_n  = pbad_q;
`endif
                  state_n = IDLE;
               end else begin
                  s_n = s_q + S_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are driven bit by bit on
// the tick grid, the expected word/flags are queued when each frame starts,
// and a monitor pops and compares on every rx_done_tick.
module tb_uart_rx;

   localparam int unsigned DBIT = 8;
   localparam time         TCLK = 8ns;

   logic            clk = 1'b0;
   logic            rst;
   logic            tick;
   logic            rx;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;
`ifdef UART_RX_PARITY_EN
   logic            parity_err;
`endif

   uart_rx #(.DBIT(DBIT), .SB_TICK(16), .OVS(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .rx           (rx),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err   (parity_err)
`endif
   );

   always #(TCLK / 2) clk = ~clk;

   typedef struct packed {
      logic [DBIT-1:0] data;
      logic            ferr;
      logic            perr;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned done_count = 0;
   int unsigned sent_count = 0;
   int unsigned div = 68;
   int unsigned tcnt = 0;
   time         t_start;
   time         last_done_time = 0;
   logic        done_prev = 1'b0;
   logic [DBIT-1:0] last_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Tick generator: one-clk strobe every div clocks, updated off the active edge
   initial tick = 1'b0;
   always @(negedge clk) begin
      tcnt = (tcnt >= div - 1) ? 0 : tcnt + 1;
      tick = (tcnt == div - 1);
   end

   // Waits for n consumed ticks; returns just after the consuming posedge
   task automatic wait_ticks(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         while (tick !== 1'b1) @(posedge clk);
      end
   endtask

   // Drives one frame; stop_ok=0 holds the stop bit low for its sampling window
   task automatic send_frame(input logic [DBIT-1:0] data, input logic stop_ok,
                             input logic par_bit, input int unsigned gap);
      exp_t e;
      e.data = data;
      e.ferr = ~stop_ok;
`ifdef UART_RX_PARITY_EN
      e.perr = (^data) ^ par_bit;
`else
      e.perr = 1'b0;
      if (par_bit) e.perr = 1'b0;
`endif
      sb_q.push_back(e);
      sent_count++;
      last_data = data;
      t_start = $time;
      #1 rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < int'(DBIT); i++) begin
         #1 rx = data[i];
         wait_ticks(16);
      end
`ifdef UART_RX_PARITY_EN
      #1 rx = par_bit;
      wait_ticks(16);
`endif
      if (stop_ok) begin
         #1 rx = 1'b1;
         wait_ticks(16);
      end else begin
         #1 rx = 1'b0;
         wait_ticks(10);
         #1 rx = 1'b1;
         wait_ticks(6);
      end
      #1 rx = 1'b1;
      wait_ticks(gap);
   endtask

   // Monitor: pop and compare on every completion
   always @(negedge clk) begin
      if (rst === 1'b1 && rx_done_tick === 1'b1) begin
         exp_t e;
         done_count++;
         last_done_time = $time;
         chk("done_width", 32'(done_prev), 32'd0);
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("dout", 32'(dout), 32'(e.data));
            chk("frame_err", 32'(frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
            chk("parity_err", 32'(parity_err), 32'(e.perr));
`endif
         end
      end
      done_prev = rx_done_tick;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      rx  = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_done", 32'(rx_done_tick), 32'd0);
      chk("reset_ferr", 32'(frame_err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      wait_ticks(4);

      // 0xA5 at 115200 baud grid, with completion latency in clocks
      send_frame(8'hA5, 1'b1, 1'b0, 2);
      chk("a5_latency", 32'((last_done_time - TCLK / 2 - t_start) / TCLK), 32'(152 * 68));
      chk("a5_drained", 32'(sb_q.size()), 32'd0);

      // Faster tick for the remaining traffic to keep the run short
      div = 5;
      wait_ticks(4);

      // Back-to-back 0x00 then 0xFF
      send_frame(8'h00, 1'b1, 1'b0, 0);
      send_frame(8'hFF, 1'b1, 1'b1, 4);
      chk("b2b_count", done_count, sent_count);

      // Short low pulse from idle: must be rejected
      #1 rx = 1'b0;
      wait_ticks(4);
      #1 rx = 1'b1;
      wait_ticks(40);
      chk("glitch_no_done", done_count, sent_count);
      chk("glitch_dout", 32'(dout), 32'(last_data));

      // Bad stop bit, then a good frame clears frame_err
      send_frame(8'h3C, 1'b0, 1'b0, 0);
      send_frame(8'h11, 1'b1, 1'b1, 4);
      chk("ferr_cleared", 32'(frame_err), 32'd0);

      // Reset during the 4th data bit of 0x55
      #1 rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 3; i++) begin
         #1 rx = (8'h55 >> i) & 8'h01 ? 1'b1 : 1'b0;
         wait_ticks(16);
      end
      #1 rx = 1'b0;
      wait_ticks(8);
      #1 rst = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      chk("midreset_dout", 32'(dout), 32'd0);
      chk("midreset_ferr", 32'(frame_err), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      wait_ticks(20);
      chk("midreset_no_done", done_count, sent_count);
      send_frame(8'h81, 1'b1, 1'b0, 4);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 4);
      send_frame(8'h07, 1'b1, 1'b0, 4);
`endif

      // Random traffic
      for (int k = 0; k < 30; k++) begin
         logic [DBIT-1:0] d;
         logic            ok;
         logic            pb;
         d  = DBIT'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         pb = 1'($urandom);
         send_frame(d, ok, pb, $urandom_range(0, 6));
      end

      wait_ticks(40);
      chk("final_drained", 32'(sb_q.size()), 32'd0);
      chk("final_count", done_count, sent_count);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that deserialises one asynchronous serial line into parallel bytes.
- Sits directly downstream of the baud rate generator and consumes its 16x oversampling tick.
- Samples each bit at mid-bit, shifts data in LSB first, and pulses a one-clock done strobe with the assembled word plus a framing error flag.
- Output feeds the receive FIFO / host interface.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVS, 16, oversampling ticks per bit; must match the baud generator (fixed 16 in this design).

Ports:
- clk  input  1  system clock (125 MHz).
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  oversampling strobe from the baud rate generator, one clk wide, 16 per bit period.
- rx  input  1  serial input line, idle high, asynchronous to clk.
- dout  output  DBIT  last received data word, LSB = first bit on the wire.
- rx_done_tick  output  1  one-clk pulse when a frame completes (good or bad).
- frame_err  output  1  valid with rx_done_tick: 1 if the stop bit sampled 0; held until the next frame completes.

Behaviour:
- Reset (rst=0, async): state=IDLE; s (tick counter, 5 bits) = 0; n (bit counter) = 0; shift register = 0; dout = 0; rx_done_tick = 0; frame_err = 0; synchroniser flops = 1.
- rx passes through a 2-flop synchroniser (reset to 1). All decisions use rx_s (synchronised rx), which adds 2 clk of latency.
- Counters advance only on clk edges where tick=1. With tick=0, all state holds.
- IDLE: when rx_s=0, go to START and set s=0. No tick is needed to leave IDLE.
- START: on each tick, s++. When s==7 on a tick (mid start bit):
  - rx_s=0: go to DATA, s=0, n=0.
  - rx_s=1: glitch; go back to IDLE with no done pulse and no error.
- DATA: on each tick, s++. When s==15 on a tick: shift reg = {rx_s, shreg[DBIT-1:1]}, s=0.
  - n==DBIT-1: go to STOP (or PARITY, see Optional Feature).
  - otherwise n++.
- STOP: on each tick, s++. When s==SB_TICK-1 on a tick:
  - dout <= shift reg.
  - frame_err <= ~rx_s.
  - rx_done_tick = 1 for exactly that clk.
  - go to IDLE.
- Line held low (break): the frame completes with frame_err=1. IDLE then sees rx_s=0 and starts a new frame; this is accepted behaviour.
- Next-frame start: a falling edge arriving in the same clk as done is detected in IDLE on the following clk. There is no lost frame at back-to-back 1-stop-bit traffic.
- Reset mid-frame: immediate return to IDLE; partial data is discarded; dout is cleared.
- Counter widths:
  - s must hold SB_TICK-1 (max 31).
  - n is $clog2(DBIT) bits.
  - No wrap-around occurs in legal operation.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP and output port parity_err (1 bit, reset 0).
  - Parameter PAR_ODD (default 0 = even parity).
  - PARITY samples at s==15 on a tick, computes the XOR of the data bits and rx_s, and flags a mismatch against even/odd.
  - parity_err updates together with rx_done_tick and holds until the next frame completes.
- Not defined: no PARITY state and no parity_err port; DATA goes directly to STOP.

Test Plan:
- Baud 115200 (tick every 68 clk). Send 0xA5, 8N1 -> rx_done_tick pulses once ~10 bit times after the start edge; dout=0xA5; frame_err=0.
- Send 0x00 then immediately 0xFF, back-to-back with 1 stop bit -> two done pulses; dout=0x00 then 0xFF; no frame lost.
- rx low pulse of 4 ticks (shorter than half a bit) from idle -> FSM returns to IDLE; no rx_done_tick; dout unchanged.
- Frame 0x3C with the stop bit driven 0 -> done pulse; dout=0x3C; frame_err=1. A following good frame 0x11 clears frame_err to 0.
- Assert rst=0 during the 4th data bit of 0x55, release, then send 0x81 -> dout=0 after reset; the next done gives dout=0x81 with no residual bits.
- With UART_RX_PARITY_EN, even parity: send 0x07 with parity bit 1 -> parity_err=0; send 0x07 with parity bit 0 -> parity_err=1.
